// File: rtl/uart_rx_frame_fsm_if.sv
// Receive-side word handshake between uart_rx_frame_fsm (master) and its consumer (slave).
`timescale 1ns/1ps

interface uart_rx_frame_fsm_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 parity_err_o;

  modport master (
    output data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o,
    output parity_err_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o,
    input  parity_err_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_frame_fsm.sv
// UART receive frame controller on the 16x clock; drives an external 4-bit bit-sample counter.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_rx_frame_fsm #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SAMPLE_MID = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_i,
  input  logic [3:0]                 sample_count_i,
  output logic                       sample_en_o,
  uart_rx_frame_fsm_if.master        rx_if
);

  localparam logic [3:0]        MidCnt  = 4'(SAMPLE_MID);
  localparam int unsigned       IdxW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic                 w_mid;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic [IdxW-1:0]      r_bit_idx;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_shift_en;
  logic                 w_idx_clr;
  logic                 w_load;
  logic                 w_frame_err;
  logic                 w_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
  logic                 w_par_sample;
  logic                 w_parity_err;
`endif

  assign w_rx_s = r_sync2;
  assign w_mid  = (sample_count_i == MidCnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    sample_en_o = 1'b1;
    w_shift_en  = 1'b0;
    w_idx_clr   = 1'b0;
    w_load      = 1'b0;
    w_frame_err = 1'b0;
    w_overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
    w_parity_err = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        // Dropping the enable is what clears the external counter between frames.
        sample_en_o = 1'b0;
        if (!w_rx_s) begin
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_mid) begin
          if (!w_rx_s) begin
            w_state_d = StData;
            w_idx_clr = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StData: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == LastIdx) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_mid) begin
          w_par_sample = 1'b1;
          w_state_d    = StStop;
        end
      end
`endif
      StStop: begin
        if (w_mid) begin
          w_state_d = StIdle;
          if (!w_rx_s) begin
            w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_bad) begin
            w_parity_err = 1'b1;
`endif
          end else if (r_valid && !rx_if.ready_i) begin
            w_overrun = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_shift     <= '0;
      r_data      <= '0;
      r_bit_idx   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= rx_i;
      r_sync2     <= r_sync1;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + IdxW'(1);
      end
      // Right shift so the first data bit lands in the LSB after the last sample.
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
      if (w_load) begin
        r_data <= r_shift;
      end
      // A load wins over a same-cycle transfer so the new word stays presented.
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (r_valid && rx_if.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err;
      if (w_idx_clr) begin
        r_par_bad <= 1'b0;
      end else if (w_par_sample) begin
        r_par_bad <= (^r_shift) ^ w_rx_s;
      end
    end
  end

  assign rx_if.parity_err_o = r_parity_err;
`else
  assign rx_if.parity_err_o = 1'b0;
`endif

  assign rx_if.data_o      = r_data;
  assign rx_if.valid_o     = r_valid;
  assign rx_if.frame_err_o = r_frame_err;
  assign rx_if.overrun_o   = r_overrun;

endmodule
